// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
// Optional ADDER_PIPE_SUB_EN adds a subtract flag to the stage record.
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Width-independent part of a stage record; the operand and sum
  // slices are added by the top, which knows WIDTH.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
`ifdef ADDER_PIPE_SUB_EN
    logic sub;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry adder slice.
// Ports: a, b operands; ci carry in; s sum; co carry out.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[W];
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// WIDTH-bit adder split into STAGES chunks, one chunk per pipeline
// stage, valid/ready at both ends. Ports: clk, rst_n (sync, low),
// in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/ovf out.
// Macro ADDER_PIPE_SUB_EN adds input sub: result = a - b - cin.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int MSB   = WIDTH - 1;

  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_cfg_err
    $error("adder_pipe_nbit: WIDTH must be a multiple of STAGES");
  end

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t st [STAGES];

  logic             v_in   [STAGES];
  logic [WIDTH-1:0] op_a   [STAGES];
  logic [WIDTH-1:0] op_b   [STAGES];
  logic             c_in   [STAGES];
  logic [WIDTH-1:0] sum_in [STAGES];
  logic [CHUNK-1:0] s_w    [STAGES];
  logic             co_w   [STAGES];
  logic [WIDTH-1:0] sum_nx [STAGES];
  logic             ovf_nx [STAGES];
  logic             go     [STAGES+1];
`ifdef ADDER_PIPE_SUB_EN
  logic             sub_in [STAGES];
`endif

  // Effective B operand and carry-in; b' travels down the pipe so
  // the overflow rule sees the operand actually added.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef ADDER_PIPE_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  always_comb begin
    v_in[0]   = in_valid;
    op_a[0]   = a;
    op_b[0]   = b_eff;
    c_in[0]   = c_eff;
    sum_in[0] = '0;
`ifdef ADDER_PIPE_SUB_EN
    sub_in[0] = sub;
`endif
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]   = st[k-1].ctl.valid;
      op_a[k]   = st[k-1].a;
      op_b[k]   = st[k-1].b;
      c_in[k]   = st[k-1].ctl.carry;
      sum_in[k] = st[k-1].sum;
`ifdef ADDER_PIPE_SUB_EN
      sub_in[k] = st[k-1].ctl.sub;
`endif
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    adder_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a (op_a[k][k*CHUNK +: CHUNK]),
      .b (op_b[k][k*CHUNK +: CHUNK]),
      .ci(c_in[k]),
      .s (s_w[k]),
      .co(co_w[k])
    );
  end

  // Only the last stage's ovf reaches the port; earlier copies are
  // computed on partial sums and never observed.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_nx[k] = sum_in[k];
      sum_nx[k][k*CHUNK +: CHUNK] = s_w[k];
      ovf_nx[k] = (op_a[k][MSB] == op_b[k][MSB])
               && (s_w[k][CHUNK-1] != op_a[k][MSB]);
    end
  end

  // A stage may load when it is empty or its contents move on.
  always_comb begin
    go[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go[k] = !st[k].ctl.valid || go[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (go[k]) begin
          st[k].ctl.valid <= v_in[k];
          if (v_in[k]) begin
            st[k].ctl.carry <= co_w[k];
            st[k].ctl.ovf   <= ovf_nx[k];
            st[k].sum       <= sum_nx[k];
            st[k].a         <= op_a[k];
            st[k].b         <= op_b[k];
`ifdef ADDER_PIPE_SUB_EN
            st[k].ctl.sub   <= sub_in[k];
`endif
          end
        end
      end
    end
  end

  assign in_ready  = go[0];
  assign out_valid = st[STAGES-1].ctl.valid;
  assign sum       = st[STAGES-1].sum;
  assign cout      = st[STAGES-1].ctl.carry;
  assign ovf       = st[STAGES-1].ctl.ovf;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench for adder_pipe_nbit (WIDTH=32, STAGES=4).
// Reference model uses plain 33-bit arithmetic and an ordered queue.
module tb_adder_pipe_nbit;

  localparam int W  = 32;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_v;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic acc_in;
  logic acc_out;

  adder_pipe_nbit #(
    .WIDTH (W),
    .STAGES(ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADDER_PIPE_SUB_EN
    .sub      (sub_v),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb, input int t);
    logic [W:0] r;
    exp_t e;
    if (sb) begin
      r   = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
      e.c = ~r[W];
      e.o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r   = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      e.c = r[W];
      e.o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    e.s = r[W-1:0];
    e.t = t;
    return e;
  endfunction

  task automatic sample();
    @(negedge clk);
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sample();
    n_vec++;
    if ({out_valid, sum, cout, ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_out: got v=%b sum=%h c=%b o=%b, required all 0",
               out_valid, sum, cout, ovf);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, required 1", in_ready);
    end
    next();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] ts [3];
    logic [1:0]   tco [3];
    exp_t e;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h1;         ts[0] = 32'h0;         tco[0] = 2'b10;
    ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h1;         ts[1] = 32'h8000_0000; tco[1] = 2'b01;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; ts[2] = 32'h0;         tco[2] = 2'b11;
    out_ready = 1'b1;
    sub_v     = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 3);
      a   = (i < 3) ? ta[i] : $urandom;
      b   = (i < 3) ? tb[i] : $urandom;
      cin = 1'b0;
      sample();
      if (acc_in) begin
        e.s = ts[i]; e.c = tco[i][1]; e.o = tco[i][0]; e.t = cyc;
        q.push_back(e);
      end
      if (acc_out) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL dir_spurious: got output sum=%h, required none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
            n_err++;
            $display("FAIL dir_result: got %h/%b/%b, required %h/%b/%b",
                     sum, cout, ovf, e.s, e.c, e.o);
          end
          n_vec++;
          if (cyc - e.t != ST) begin
            n_err++;
            $display("FAIL dir_latency: got %0d, required %0d", cyc - e.t, ST);
          end
        end
      end
      next();
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL dir_drain: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int outs = 0;
    out_ready = 1'b1;
    sub_v     = 1'b0;
    for (int i = 0; i < 26; i++) begin
      in_valid = (i < 16);
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sample();
      if (i < 16) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready: got %b, required 1 at step %0d", in_ready, i);
        end
      end
      if (acc_in) q.push_back(model(a, b, cin, sub_v, cyc));
      if (acc_out) begin
        outs++;
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_spurious: got output sum=%h, required none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
            n_err++;
            $display("FAIL b2b_result: got %h/%b/%b, required %h/%b/%b",
                     sum, cout, ovf, e.s, e.c, e.o);
          end
          n_vec++;
          if (cyc - e.t != ST) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d, required %0d", cyc - e.t, ST);
          end
        end
      end
      next();
    end
    n_vec++;
    if (outs != 16 || q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d outputs %0d pending, required 16 and 0",
               outs, q.size());
      q.delete();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [W+1:0] held;
    sub_v = 1'b0;
    held  = '0;
    for (int i = 0; i < 34; i++) begin
      out_ready = !(i >= 4 && i < 10);
      if (i < 4 || i >= 11) begin
        in_valid = (i < 4) ? 1'b1 : (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
      end else if (i == 4) begin
        in_valid = 1'b1;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
      end
      sample();
      if (i >= 4 && i < 10) begin
        n_vec++;
        if ({out_valid, in_ready} !== 2'b10) begin
          n_err++;
          $display("FAIL bp_stall: got out_valid=%b in_ready=%b, required 1/0",
                   out_valid, in_ready);
        end
        if (i == 4) held = {sum, cout, ovf};
        else begin
          n_vec++;
          if ({sum, cout, ovf} !== held) begin
            n_err++;
            $display("FAIL bp_hold: got %h, required %h", {sum, cout, ovf}, held);
          end
        end
      end
      if (acc_in) q.push_back(model(a, b, cin, sub_v, cyc));
      if (acc_out) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL bp_spurious: got output sum=%h, required none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
            n_err++;
            $display("FAIL bp_result: got %h/%b/%b, required %h/%b/%b",
                     sum, cout, ovf, e.s, e.c, e.o);
          end
        end
      end
      next();
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

`ifdef ADDER_PIPE_SUB_EN
  task automatic test_sub();
    exp_t e;
    logic [W-1:0] ts [2];
    logic         tc [2];
    ts[0] = 32'hFFFF_FFFE; tc[0] = 1'b0;
    ts[1] = 32'h2;         tc[1] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 10);
      if (i < 2) begin
        a = (i == 0) ? 32'd5 : 32'd7;
        b = (i == 0) ? 32'd7 : 32'd5;
        cin   = 1'b0;
        sub_v = 1'b1;
      end else begin
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom_range(0, 1));
        sub_v = 1'($urandom_range(0, 1));
      end
      sample();
      if (acc_in) begin
        e = model(a, b, cin, sub_v, cyc);
        if (i < 2) begin
          e.s = ts[i];
          e.c = tc[i];
          e.o = 1'b0;
        end
        q.push_back(e);
      end
      if (acc_out) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL sub_spurious: got output sum=%h, required none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
            n_err++;
            $display("FAIL sub_result: got %h/%b/%b, required %h/%b/%b",
                     sum, cout, ovf, e.s, e.c, e.o);
          end
        end
      end
      next();
    end
    sub_v = 1'b0;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL sub_drain: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask
`endif

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    sub_v     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sample();
      next();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sample();
    next();
    rst_n = 1'b1;
    sample();
    n_vec++;
    if ({out_valid, sum, cout, ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_flight_out: got v=%b sum=%h c=%b o=%b, required all 0",
               out_valid, sum, cout, ovf);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_flight_ready: got %b, required 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      next();
      sample();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale: got out_valid=%b sum=%h, required 0",
                 out_valid, sum);
      end
    end
    next();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub_v     = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
`ifdef ADDER_PIPE_SUB_EN
    test_sub();
`endif
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, required finish");
    $fatal(1);
  end

endmodule
